// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester handshakes (fetch port F, data port D) and the
// single-port memory bus that the arbiter drives.
//   f_req/f_addr          -> fetch request and address (requester drives)
//   f_ack/f_rdata         <- fetch done pulse and held read data
//   d_req/d_we/d_addr/
//   d_wdata/d_lock        -> data request, direction, address, data, lock
//   d_ack/d_rdata         <- data done pulse and held read data
//   mem_addr/mem_we/
//   mem_wdata             <- memory address, write enable, write data
//   mem_rdata             -> combinational memory read data
//   busy                  <- arbiter is in the middle of an access
// Modport slave is the arbiter's view; modport master is the view of the
// requesters plus the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    input  mem_rdata,
    output f_ack, f_rdata,
    output d_ack, d_rdata,
    output mem_addr, mem_we, mem_wdata,
    output busy
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    output mem_rdata,
    input  f_ack, f_rdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter and access sequencer in front of a single-port
// memory. Port F (instruction fetch, read only) and port D (data, read or
// write, with an optional lock for read-modify-write) each use a level-held
// req/ack handshake. Each access takes IDLE -> ACCESS -> RESP; the ack pulse
// is issued in RESP together with the registered read data.
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: requester handshakes and memory bus
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  owner_t            r_last_owner;
  owner_t            w_grant_owner;
  logic              w_grant;
  logic              w_f_elig;
  logic              r_locked;

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  // While port D holds the lock, fetch requests are ignored entirely.
  assign w_f_elig = bus.f_req & ~r_locked;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and grant decision
  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_grant_owner = OWN_F;
    case (r_state)
      ST_IDLE: begin
        if (w_f_elig && bus.d_req) begin
          // Tie: the port that was not served last wins.
          w_grant       = 1'b1;
          w_grant_owner = (r_last_owner == OWN_D) ? OWN_F : OWN_D;
        end else if (w_f_elig) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_F;
        end else if (bus.d_req) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_D;
        end
        if (w_grant) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Captured request, ownership, lock and per-port read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_F;
      r_last_owner <= OWN_D;
      r_locked     <= 1'b0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_f_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OWN_D) begin
          r_addr  <= bus.d_addr;
          r_we    <= bus.d_we;
          r_wdata <= bus.d_wdata;
        end else begin
          // Fetch is read only; the write-data register keeps its old value.
          r_addr <= bus.f_addr;
          r_we   <= 1'b0;
        end
      end

      // Memory read data is combinational, so sampling it at the end of
      // ACCESS returns the pre-write contents on a D write.
      if (r_state == ST_ACCESS) begin
        if (r_owner == OWN_D) begin
          r_d_rdata <= bus.mem_rdata;
        end else begin
          r_f_rdata <= bus.mem_rdata;
        end
      end

      if (r_state == ST_RESP) begin
        r_locked     <= (r_owner == OWN_D) & bus.d_lock;
        r_last_owner <= r_owner;
      end
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = (r_state == ST_ACCESS) & r_we;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.f_ack     = (r_state == ST_RESP) & (r_owner == OWN_F);
  assign bus.d_ack     = (r_state == ST_RESP) & (r_owner == OWN_D);
  assign bus.f_rdata   = r_f_rdata;
  assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter: a 4096x16 memory with combinational read, a
// transaction-level reference model (each grant at edge g means ACCESS in
// cycle g, ack in cycle g+1, next grant no earlier than edge g+3), directed
// scenarios with literal expectations, then a randomized phase.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] tb_mem  [4096];
  logic [DW-1:0] ref_mem [4096];

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] h;
    case (a)
      5:       return 16'h7A31;
      'h100:   return 16'h1234;
      'h200:   return 16'h0041;
      default: begin
        h = 32'(a) * 32'd40503;
        return h[15:0] ^ 16'h3C5A;
      end
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory unit: combinational read, write on the rising edge.
  assign bus.mem_rdata = tb_mem[bus.mem_addr];
  initial begin
    for (int i = 0; i < 4096; i++) tb_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int n_cmp;
  int n_fail;
  int cyc;
  int obs_busy, obs_we, obs_fack, obs_dack;

  // Reference model state
  int          g;
  bit          m_port;    // 0 = F, 1 = D
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit          m_last;
  bit          m_locked;
  logic [DW-1:0] e_frd, e_drd;
  bit          e_busy, e_fack, e_dack, e_we;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    g        = -100;
    m_port   = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_last   = 1'b1;
    m_locked = 1'b0;
    e_frd    = '0;
    e_drd    = '0;
    e_busy   = 1'b0;
    e_fack   = 1'b0;
    e_dack   = 1'b0;
    e_we     = 1'b0;
  endtask

  // Apply the arbitration rules for the edge that ends cycle cyc, using the
  // inputs currently presented, and derive expectations for cycle cyc+1.
  task automatic predict();
    logic [DW-1:0] rd;
    bit fw, dw, port;
    int k;
    k = cyc;
    if (k == g) begin
      rd = ref_mem[m_addr];
      if (m_port) e_drd = rd;
      else        e_frd = rd;
      if (m_we) ref_mem[m_addr] = m_wdata;
    end
    if (k == g + 1) begin
      m_locked = m_port & (bus.d_lock == 1'b1);
      m_last   = m_port;
    end
    if (k >= g + 2) begin
      fw = (bus.f_req == 1'b1) && !m_locked;
      dw = (bus.d_req == 1'b1);
      if (fw || dw) begin
        port   = (fw && dw) ? !m_last : dw;
        g      = k + 1;
        m_port = port;
        if (port) begin
          m_addr  = bus.d_addr;
          m_we    = bus.d_we;
          m_wdata = bus.d_wdata;
        end else begin
          m_addr = bus.f_addr;
          m_we   = 1'b0;
        end
      end
    end
    cyc    = k + 1;
    e_busy = (cyc == g) || (cyc == g + 1);
    e_fack = (cyc == g + 1) && !m_port;
    e_dack = (cyc == g + 1) && m_port;
    e_we   = (cyc == g) && m_we;
  endtask

  task automatic compare();
    obs_busy += int'(bus.busy);
    obs_we   += int'(bus.mem_we);
    obs_fack += int'(bus.f_ack);
    obs_dack += int'(bus.d_ack);
    chk("busy",     32'(bus.busy),     32'(e_busy));
    chk("f_ack",    32'(bus.f_ack),    32'(e_fack));
    chk("d_ack",    32'(bus.d_ack),    32'(e_dack));
    chk("mem_we",   32'(bus.mem_we),   32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    chk("f_rdata",  32'(bus.f_rdata),  32'(e_frd));
    chk("d_rdata",  32'(bus.d_rdata),  32'(e_drd));
    if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    if (bus.f_ack === 1'b1)
      $display("cyc %0d F ack addr=%03h rdata=%04h", cyc, bus.mem_addr, bus.f_rdata);
    if (bus.d_ack === 1'b1)
      $display("cyc %0d D ack addr=%03h we=%0d rdata=%04h", cyc, bus.mem_addr, m_we, bus.d_rdata);
  endtask

  task automatic tick();
    predict();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_port_ack(input bit port, output int lat);
    lat = 99;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if ((port ? bus.d_ack : bus.f_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic clr_obs();
    obs_busy = 0; obs_we = 0; obs_fack = 0; obs_dack = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_f_ack"},     32'(bus.f_ack),     32'd0);
    chk({tag, "_d_ack"},     32'(bus.d_ack),     32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_f_rdata"},   32'(bus.f_rdata),   32'd0);
    chk({tag, "_d_rdata"},   32'(bus.d_rdata),   32'd0);
  endtask

  initial begin
    int lat, lat2;
    int seq[$];
    int acyc[$];
    int d_acks;
    logic [DW-1:0] rmw_old;

    n_cmp = 0; n_fail = 0; cyc = 0;
    clr_obs();
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    model_reset();

    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_lock = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // F reads 0x005
    clr_obs();
    bus.f_addr = 12'h005; bus.f_req = 1'b1;
    wait_port_ack(1'b0, lat);
    bus.f_req = 1'b0;
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_f_rdata", 32'(bus.f_rdata), 32'h7A31);
    tick(); tick();
    chk("t1_busy_cycles", 32'(obs_busy), 32'd2);
    chk("t1_no_d_ack", 32'(obs_dack), 32'd0);

    // D writes 0xBEEF to 0x100 then reads it back
    clr_obs();
    bus.d_we = 1'b1; bus.d_addr = 12'h100; bus.d_wdata = 16'hBEEF; bus.d_lock = 1'b0; bus.d_req = 1'b1;
    wait_port_ack(1'b1, lat);
    bus.d_req = 1'b0;
    chk("t2_wr_latency", 32'(lat), 32'd2);
    chk("t2_wr_old_data", 32'(bus.d_rdata), 32'h1234);
    tick();
    bus.d_we = 1'b0; bus.d_req = 1'b1;
    wait_port_ack(1'b1, lat);
    bus.d_req = 1'b0;
    chk("t2_rd_data", 32'(bus.d_rdata), 32'hBEEF);
    tick();
    chk("t2_we_cycles", 32'(obs_we), 32'd1);

    // Both ports held: grants alternate F, D, F, D
    bus.f_req = 1'b1; bus.f_addr = 12'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (bus.f_ack === 1'b1) begin
        seq.push_back(0); acyc.push_back(cyc);
        bus.f_addr = 12'($urandom_range(0, 63));
      end
      if (bus.d_ack === 1'b1) begin
        seq.push_back(1); acyc.push_back(cyc);
        bus.d_addr = 12'($urandom_range(0, 63));
      end
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick();
    chk("t3_ack_count", 32'(seq.size()), 32'd4);
    for (int j = 0; j < seq.size() && j < 4; j++) begin
      chk("t3_owner", 32'(seq[j]), 32'(j % 2));
      if (j > 0) chk("t3_spacing", 32'(acyc[j] - acyc[j-1]), 32'd3);
    end

    // Locked read-modify-write of 0x200 while F is waiting
    seq.delete();
    d_acks = 0;
    rmw_old = '0;
    bus.d_we = 1'b0; bus.d_addr = 12'h200; bus.d_lock = 1'b1; bus.d_req = 1'b1;
    tick();
    bus.f_addr = 12'h011; bus.f_req = 1'b1;
    for (int i = 0; i < 30 && seq.size() < 3; i++) begin
      tick();
      if (d_acks == 1 && bus.d_req === 1'b1 && bus.d_ack !== 1'b1) bus.d_lock = 1'b0;
      if (bus.d_ack === 1'b1) begin
        seq.push_back(1);
        d_acks++;
        if (d_acks == 1) begin
          rmw_old = bus.d_rdata;
          bus.d_we = 1'b1; bus.d_wdata = bus.d_rdata + 16'd1;
        end else begin
          bus.d_req = 1'b0; bus.d_we = 1'b0;
        end
      end
      if (bus.f_ack === 1'b1) begin
        seq.push_back(0);
        bus.f_req = 1'b0;
      end
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0; bus.d_lock = 1'b0;
    tick();
    chk("t4_ack_count", 32'(seq.size()), 32'd3);
    for (int j = 0; j < seq.size() && j < 3; j++)
      chk("t4_order", 32'(seq[j]), (j < 2) ? 32'd1 : 32'd0);
    chk("t4_old_value", 32'(rmw_old), 32'h0041);
    chk("t4_mem_200", 32'(tb_mem[12'h200]), 32'h0042);

    // Reset during the ACCESS cycle of a D write
    clr_obs();
    bus.d_we = 1'b1; bus.d_addr = 12'h300; bus.d_wdata = 16'hDEAD; bus.d_req = 1'b1;
    tick();
    chk("t5_in_access_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t5_rst");
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    model_reset();
    @(negedge clk);
    cyc++;
    compare();
    chk("t5_no_write", 32'(tb_mem[12'h300]), 32'(init_word('h300)));
    chk("t5_no_d_ack", 32'(obs_dack), 32'd0);
    rst = 1'b0;
    // Simultaneous requests after reset: F first, then D
    bus.f_addr = 12'h005; bus.f_req = 1'b1;
    bus.d_addr = 12'h100; bus.d_we = 1'b0; bus.d_req = 1'b1;
    wait_port_ack(1'b0, lat);
    bus.f_req = 1'b0;
    chk("t5_f_latency", 32'(lat), 32'd2);
    chk("t5_f_rdata", 32'(bus.f_rdata), 32'h7A31);
    chk("t5_d_not_first", 32'(obs_dack), 32'd0);
    wait_port_ack(1'b1, lat2);
    bus.d_req = 1'b0;
    chk("t5_d_latency", 32'(lat2), 32'd3);
    chk("t5_d_rdata", 32'(bus.d_rdata), 32'hBEEF);
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (bus.f_req === 1'b1) begin
        if (e_fack) begin
          if ($urandom_range(0, 1) == 1) bus.f_addr = 12'($urandom_range(0, 31));
          else bus.f_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.f_addr = 12'($urandom_range(0, 31));
        bus.f_req  = 1'b1;
      end
      if (bus.d_req === 1'b1) begin
        if (e_dack) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.d_addr  = 12'($urandom_range(0, 31));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = 16'($urandom);
            bus.d_lock  = ($urandom_range(0, 3) == 0);
          end else begin
            bus.d_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 1) == 0) begin
        bus.d_addr  = 12'($urandom_range(0, 31));
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_wdata = 16'($urandom);
        bus.d_lock  = ($urandom_range(0, 3) == 0);
        bus.d_req   = 1'b1;
      end
    end
    for (int a = 0; a < 32; a++)
      chk("mem_final", 32'(tb_mem[a]), 32'(ref_mem[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
